// File: rtl/multi_timer.sv
// Multi-channel BCD HH:MM:SS.cc timer: shared centisecond prescaler, shared command port,
// one timer channel instance per output lane.

module multi_timer_ch (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        cmd_hit_i,
    input  logic [1:0]  cmd_op_i,
    input  logic        cmd_mode_i,
    input  logic [23:0] cmd_value_i,
    output logic [23:0] display_o,
    output logic        running_o,
    output logic        expired_o
);
    localparam logic [1:0] OP_PAUSE = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    // digit 7..0 = H1 H0 M1 M0 S1 S0 C1 C0
    logic [7:0][3:0] dig_q, dig_d, step_dig;
    logic            mode_q, mode_d;
    logic            run_q, run_d;
    logic            exp_q, exp_d;

    // One centisecond step; S1 (3) and M1 (5) are base-6 digits, all others base-10.
    always_comb begin
        logic       c;
        logic [3:0] lim;
        c        = 1'b1;
        step_dig = dig_q;
        for (int i = 0; i < 8; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (!mode_q) begin
                    if (dig_q[i] == 4'd0) begin
                        step_dig[i] = lim;
                    end else begin
                        step_dig[i] = dig_q[i] - 4'd1;
                        c           = 1'b0;
                    end
                end else begin
                    if (dig_q[i] == lim) begin
                        step_dig[i] = 4'd0;
                    end else begin
                        step_dig[i] = dig_q[i] + 4'd1;
                        c           = 1'b0;
                    end
                end
            end
        end
    end

    // An accepted command on this channel swallows a coincident tick.
    always_comb begin
        dig_d  = dig_q;
        mode_d = mode_q;
        run_d  = run_q;
        exp_d  = 1'b0;
        if (cmd_hit_i) begin
            case (cmd_op_i)
                OP_PAUSE: run_d = 1'b0;
                OP_START: if (mode_q || dig_q != '0) run_d = 1'b1;
                OP_CLEAR: begin
                    dig_d = '0;
                    run_d = 1'b0;
                end
                OP_LOAD: begin
                    dig_d  = {cmd_value_i, 8'h00};
                    mode_d = cmd_mode_i;
                    run_d  = 1'b0;
                end
                default: ;
            endcase
        end else if (tick_i && run_q) begin
            dig_d = step_dig;
            // All-zero after a step means countdown reached zero or count-up wrapped.
            if (step_dig == '0) begin
                run_d = 1'b0;
                exp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dig_q  <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
            exp_q  <= 1'b0;
        end else begin
            dig_q  <= dig_d;
            mode_q <= mode_d;
            run_q  <= run_d;
            exp_q  <= exp_d;
        end
    end

    assign display_o = dig_q[7:2];
    assign running_o = run_q;
    assign expired_o = exp_q;
endmodule

module multi_timer #(
    parameter  int CHANNELS = 2,
    parameter  int TICK_DIV = 1000000,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_valid_i,
    input  logic [CHW-1:0]           cmd_ch_i,
    input  logic [1:0]               cmd_op_i,
    input  logic                     cmd_mode_i,
    input  logic [23:0]              cmd_value_i,
    output logic [24*CHANNELS-1:0]   display_o,
    output logic [CHANNELS-1:0]      running_o,
    output logic [CHANNELS-1:0]      expired_o,
    output logic                     cmd_err_o
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]              pre_q;
    logic                       tick;
    logic                       load_ok, ch_ok, accept;
    logic                       err_q, err_d;
    logic [CHANNELS-1:0]        ch_hit;
    logic [CHANNELS-1:0][23:0]  disp;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // Free-running: commands never disturb the tick phase.
    always_ff @(posedge clk_i) begin
        if (reset_i) pre_q <= '0;
        else         pre_q <= tick ? '0 : pre_q + PW'(1);
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (cmd_value_i[i*4 +: 4] > 4'd9) load_ok = 1'b0;
        end
        if (cmd_value_i[15:12] > 4'd5 || cmd_value_i[7:4] > 4'd5) load_ok = 1'b0;
    end

    assign ch_ok  = 32'(cmd_ch_i) < CHANNELS;
    assign accept = cmd_valid_i && ch_ok && (cmd_op_i != 2'b11 || load_ok);
    assign err_d  = cmd_valid_i && !(ch_ok && (cmd_op_i != 2'b11 || load_ok));

    always_ff @(posedge clk_i) begin
        if (reset_i) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign ch_hit[g] = accept && (32'(cmd_ch_i) == g);
        multi_timer_ch u_ch (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .tick_i      (tick),
            .cmd_hit_i   (ch_hit[g]),
            .cmd_op_i    (cmd_op_i),
            .cmd_mode_i  (cmd_mode_i),
            .cmd_value_i (cmd_value_i),
            .display_o   (disp[g]),
            .running_o   (running_o[g]),
            .expired_o   (expired_o[g])
        );
    end

    assign display_o = disp;
    assign cmd_err_o = err_q;
endmodule

// File: tb/tb_multi_timer.sv
// Randomised/directed bench for multi_timer; a centisecond-integer reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.

module tb_multi_timer;
    localparam int CH    = 3;
    localparam int TD    = 4;
    localparam int MAXCS = 36000000 - 1;
    localparam int P_PAUSE = 0, P_START = 1, P_CLEAR = 2, P_LOAD = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cv = 1'b0;
    logic [1:0]        cch = '0;
    logic [1:0]        cop = '0;
    logic              cmode = 1'b0;
    logic [23:0]       cval = '0;
    logic [CH*24-1:0]  disp;
    logic [CH-1:0]     run, expd;
    logic              err;

    always #5 clk = ~clk;

    multi_timer #(.CHANNELS(CH), .TICK_DIV(TD)) dut (
        .clk_i(clk), .reset_i(rst), .cmd_valid_i(cv), .cmd_ch_i(cch), .cmd_op_i(cop),
        .cmd_mode_i(cmode), .cmd_value_i(cval), .display_o(disp), .running_o(run),
        .expired_o(expd), .cmd_err_o(err)
    );

    typedef struct {
        logic [CH*24-1:0] disp;
        logic [CH-1:0]    run;
        logic [CH-1:0]    expd;
        logic             err;
        bit               kchk;
        int               kch;
        logic [23:0]      kval;
        string            kname;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: each channel is a plain centisecond count.
    int m_cs[CH];
    bit m_mode[CH];
    bit m_run[CH];
    int m_pcnt;

    function automatic logic [23:0] cs2bcd(input int cs);
        int s, h, m, sc;
        s  = cs / 100;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic int bcd2cs(input logic [23:0] v);
        int h, m, s;
        h = int'(v[23:20]) * 10 + int'(v[19:16]);
        m = int'(v[15:12]) * 10 + int'(v[11:8]);
        s = int'(v[7:4]) * 10 + int'(v[3:0]);
        return ((h * 60 + m) * 60 + s) * 100;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] v);
        for (int i = 0; i < 6; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
        if (v[15:12] > 4'd5 || v[7:4] > 4'd5) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit v, input int ch, input int op,
                              input bit md, input logic [23:0] val);
        exp_t e;
        bit   tick;
        int   hit;
        e.expd = '0;
        e.err  = 1'b0;
        e.kchk = 1'b0;
        e.kch  = 0;
        e.kval = '0;
        e.kname = "";
        if (r) begin
            for (int n = 0; n < CH; n++) begin
                m_cs[n] = 0; m_mode[n] = 0; m_run[n] = 0;
            end
            m_pcnt = 0;
        end else begin
            tick   = (m_pcnt == TD - 1);
            m_pcnt = tick ? 0 : m_pcnt + 1;
            hit    = -1;
            if (v) begin
                if (ch >= CH) e.err = 1'b1;
                else if (op == P_LOAD && !bcd_ok(val)) e.err = 1'b1;
                else begin
                    hit = ch;
                    case (op)
                        P_PAUSE: m_run[ch] = 0;
                        P_START: if (!(m_mode[ch] == 0 && m_cs[ch] == 0)) m_run[ch] = 1;
                        P_CLEAR: begin m_cs[ch] = 0; m_run[ch] = 0; end
                        default: begin
                            m_cs[ch] = bcd2cs(val); m_mode[ch] = md; m_run[ch] = 0;
                        end
                    endcase
                end
            end
            for (int n = 0; n < CH; n++) begin
                if (n != hit && tick && m_run[n]) begin
                    if (!m_mode[n]) begin
                        m_cs[n]--;
                        if (m_cs[n] == 0) begin m_run[n] = 0; e.expd[n] = 1'b1; end
                    end else if (m_cs[n] == MAXCS) begin
                        m_cs[n] = 0; m_run[n] = 0; e.expd[n] = 1'b1;
                    end else begin
                        m_cs[n]++;
                    end
                end
            end
        end
        for (int n = 0; n < CH; n++) begin
            e.disp[n*24 +: 24] = cs2bcd(m_cs[n]);
            e.run[n]           = m_run[n];
        end
        sbq.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit v, input int ch, input int op,
                       input bit md, input logic [23:0] val);
        rst = r; cv = v; cch = 2'(ch); cop = 2'(op); cmode = md; cval = val;
        @(posedge clk);
        model_step(r, v, ch, op, md, val);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 24'h0);
    endtask

    task automatic cmd(input int ch, input int op, input bit md, input logic [23:0] val);
        cyc(0, 1, ch, op, md, val);
    endtask

    // Attach a fixed expected display value to the state produced by the last edge.
    task automatic kcheck(input int ch, input logic [23:0] val, input string name);
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_back();
            e.kchk = 1'b1; e.kch = ch; e.kval = val; e.kname = name;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_tick_edge();
        int guard = 0;
        while (m_pcnt != TD - 1 && guard < 2 * TD) begin
            idle(1);
            guard++;
        end
    endtask

    function automatic void chk(input string name, input logic [71:0] got, input logic [71:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("display", 72'(disp), 72'(mon_e.disp));
            chk("running", 72'(run), 72'(mon_e.run));
            chk("expired", 72'(expd), 72'(mon_e.expd));
            chk("cmd_err", 72'(err), 72'(mon_e.err));
            if (mon_e.kchk) chk(mon_e.kname, 72'(disp[mon_e.kch*24 +: 24]), 72'(mon_e.kval));
        end
    end

    initial begin
        logic [23:0] rv;
        int          op;
        cyc(1, 0, 0, 0, 0, 24'h0);
        cyc(1, 1, 0, P_LOAD, 0, 24'h123456);
        kcheck(0, 24'h000000, "reset_disp");

        // 2 s countdown on ch0, then restart attempt on the expired channel
        cmd(0, P_LOAD, 0, 24'h000002);
        kcheck(0, 24'h000002, "load_cd");
        cmd(0, P_START, 0, 24'h0);
        idle(820);
        kcheck(0, 24'h000000, "cd_done");
        cmd(0, P_START, 0, 24'h0);
        idle(8);

        // Count-up ch1 for exactly 7000 ticks, pause, resume
        cmd(1, P_LOAD, 1, 24'h000100);
        cmd(1, P_START, 0, 24'h0);
        idle(7000 * TD);
        kcheck(1, 24'h000210, "up_7000");
        cmd(1, P_PAUSE, 0, 24'h0);
        idle(100 * TD);
        kcheck(1, 24'h000210, "paused_hold");
        cmd(1, P_START, 0, 24'h0);
        idle(100 * TD);
        kcheck(1, 24'h000211, "resumed");

        // Countdown borrow through every digit
        cmd(0, P_LOAD, 0, 24'h010000);
        cmd(0, P_START, 0, 24'h0);
        wait_tick_edge();
        idle(1);
        kcheck(0, 24'h005959, "borrow");
        cmd(0, P_PAUSE, 0, 24'h0);

        // Count-up overflow at 99:59:59.99
        cmd(2, P_LOAD, 1, 24'h995959);
        cmd(2, P_START, 0, 24'h0);
        idle(100 * TD);
        kcheck(2, 24'h000000, "overflow");
        idle(4);

        // Rejected commands
        cmd(0, P_LOAD, 0, 24'h006000);
        kcheck(0, 24'h005959, "bad_m1");
        cmd(0, P_LOAD, 0, 24'h0A0000);
        cmd(0, P_LOAD, 0, 24'h000060);
        cmd(3, P_CLEAR, 0, 24'h0);
        cmd(3, P_LOAD, 0, 24'h000001);
        idle(2);

        // Pause ch0 on a tick edge while ch1 keeps counting
        cmd(0, P_START, 0, 24'h0);
        wait_tick_edge();
        cmd(0, P_PAUSE, 0, 24'h0);
        idle(TD + 1);

        // Reset mid-count
        cmd(0, P_START, 0, 24'h0);
        idle(9);
        cyc(1, 0, 0, 0, 0, 24'h0);
        kcheck(1, 24'h000000, "reset_mid");
        idle(2 * TD + 1);

        // Random command traffic with short values so expiries occur
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                op = $urandom_range(0, 5);
                if (op > 3) op = P_START;
                if ($urandom_range(0, 7) == 0) rv = 24'($urandom);
                else rv = {12'h000, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                           4'($urandom_range(0, 9))};
                cmd($urandom_range(0, 3), op, 1'($urandom_range(0, 1)), rv);
            end else begin
                idle(1);
            end
        end
        idle(2);
        #10;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
